// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared codes, state encoding and helpers for the SW score controller
//
// Contents:
//   _A/_G/_T/_C  2-bit nucleotide codes
//   ZERO         biased-zero score for the default 12-bit score width
//   state_t      controller state encoding
//   log2b        index width for a count of n items (minimum 1)
//   zero_score   biased-zero score for an arbitrary score width
package sw_pkg;

  localparam logic [1:0] _A = 2'b00;
  localparam logic [1:0] _G = 2'b01;
  localparam logic [1:0] _T = 2'b10;
  localparam logic [1:0] _C = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_Q = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  function automatic int log2b(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Scores are biased so that 2**(width-1) represents zero.
  function automatic int zero_score(input int width);
    return 1 << (width - 1);
  endfunction

  localparam int ZERO = zero_score(12);

endpackage

// File: rtl/sw_query_loader.sv
// rtl/sw_query_loader.sv - query register, length counter and load-end detection
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   start        clear the query register and length for a new load
//   accept       one query beat is transferred this cycle
//   q_base       base written into slot qlen on accept
//   q_last       host marks the final base
//   done         accepted beat ends the load (q_last or register full)
//   query        parallel query bus, base k on bits [2k+1:2k]
//   counter      index of the last loaded base (qlen-1)
module sw_query_loader
  import sw_pkg::*;
#(
  parameter int LENGTH     = 128,
  parameter int LOG_LENGTH = log2b(LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  accept,
  input  logic [1:0]            q_base,
  input  logic                  q_last,
  output logic                  done,
  output logic [2*LENGTH-1:0]   query,
  output logic [LOG_LENGTH-1:0] counter
);

  localparam logic [LOG_LENGTH:0] LEN_M1 = (LOG_LENGTH + 1)'(LENGTH - 1);

  // One extra bit so qlen can represent a completely full register.
  logic [LOG_LENGTH:0]   qlen;
  logic [LOG_LENGTH-1:0] slot;

  assign slot = qlen[LOG_LENGTH-1:0];
  assign done = accept && (q_last || (qlen == LEN_M1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      query   <= '0;
      qlen    <= '0;
      counter <= '0;
    end else if (start) begin
      // counter keeps its old value so the array still sees a legal index.
      query <= {LENGTH{_A}};
      qlen  <= '0;
    end else if (accept && (qlen <= LEN_M1)) begin
      query[{slot, 1'b0} +: 2] <= q_base;
      qlen                     <= qlen + 1'b1;
      counter                  <= slot;
    end
  end

endmodule

// File: rtl/sw_score_controller.sv
// rtl/sw_score_controller.sv - job sequencer for the systolic Smith-Waterman array
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   q_valid/q_ready/q_base/q_last  query base stream
//   t_valid/t_ready/t_base/t_last  target base stream
//   arr_rst                      active-low array reset (low for 2 cycles per job)
//   arr_en, arr_data             target base into PE0
//   arr_query, arr_counter       parallel query and last-active-PE index
//   arr_result, arr_vld          score returned by the array
//   res_valid/res_ready          result handshake
//   res_score, res_timeout       job score (biased) and timeout flag
//   busy                         controller is not idle
module sw_score_controller
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = 12,
  parameter int LENGTH      = 128,
  parameter int LOG_LENGTH  = log2b(LENGTH),
  parameter int TIMEOUT     = 2 * LENGTH + 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   q_valid,
  output logic                   q_ready,
  input  logic [1:0]             q_base,
  input  logic                   q_last,
  input  logic                   t_valid,
  output logic                   t_ready,
  input  logic [1:0]             t_base,
  input  logic                   t_last,
  output logic                   arr_rst,
  output logic                   arr_en,
  output logic [1:0]             arr_data,
  output logic [2*LENGTH-1:0]    arr_query,
  output logic [LOG_LENGTH-1:0]  arr_counter,
  input  logic [SCORE_WIDTH-1:0] arr_result,
  input  logic                   arr_vld,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [SCORE_WIDTH-1:0] res_score,
  output logic                   res_timeout,
  output logic                   busy
);

  localparam logic [SCORE_WIDTH-1:0] ZERO_SCORE = SCORE_WIDTH'(zero_score(SCORE_WIDTH));
  localparam int                     DW         = log2b(TIMEOUT);
  localparam logic [DW-1:0]          DRAIN_LAST = DW'(TIMEOUT - 1);

  state_t        state;
  logic          q_loaded;
  logic          clr_cnt;
  logic [DW-1:0] drain_cnt;

  logic load_start;
  logic load_accept;
  logic load_done;

  assign q_ready     = (state == ST_LOAD_Q);
  assign t_ready     = (state == ST_STREAM);
  assign busy        = (state != ST_IDLE);

  // A new query always wins over a target that arrives in the same cycle.
  assign load_start  = (state == ST_IDLE) && q_valid;
  assign load_accept = q_ready && q_valid;

  sw_query_loader #(
    .LENGTH     (LENGTH),
    .LOG_LENGTH (LOG_LENGTH)
  ) u_loader (
    .clk     (clk),
    .rst     (rst),
    .start   (load_start),
    .accept  (load_accept),
    .q_base  (q_base),
    .q_last  (q_last),
    .done    (load_done),
    .query   (arr_query),
    .counter (arr_counter)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      q_loaded    <= 1'b0;
      clr_cnt     <= 1'b0;
      drain_cnt   <= '0;
      arr_rst     <= 1'b0;
      arr_en      <= 1'b0;
      arr_data    <= 2'b00;
      res_valid   <= 1'b0;
      res_score   <= ZERO_SCORE;
      res_timeout <= 1'b0;
    end else begin
      arr_en  <= 1'b0;
      arr_rst <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (q_valid) begin
            state <= ST_LOAD_Q;
          end else if (t_valid && q_loaded) begin
            state   <= ST_CLEAR;
            arr_rst <= 1'b0;
            clr_cnt <= 1'b0;
          end
        end
        ST_LOAD_Q: begin
          if (load_done) begin
            state    <= ST_CLEAR;
            q_loaded <= 1'b1;
            arr_rst  <= 1'b0;
            clr_cnt  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          // arr_rst was driven low on entry; keep it low for one more cycle.
          if (clr_cnt) begin
            state <= ST_STREAM;
          end else begin
            clr_cnt <= 1'b1;
            arr_rst <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (t_valid) begin
            arr_en   <= 1'b1;
            arr_data <= t_base;
            if (t_last) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (arr_vld) begin
            res_score   <= arr_result;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            state       <= ST_DONE;
          end else if (drain_cnt == DRAIN_LAST) begin
            res_score   <= ZERO_SCORE;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state       <= ST_DONE;
          end else begin
            // Only increments below DRAIN_LAST, so it saturates rather than wraps.
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_score_controller.sv
// tb/tb_sw_score_controller.sv - scoreboard bench for sw_score_controller
module tb_sw_score_controller;
  import sw_pkg::*;

  localparam int SW   = 12;
  localparam int LEN  = 128;
  localparam int LOGL = 7;
  localparam int TMO  = 2 * LEN + 8;
  localparam logic [SW-1:0] ZV = 12'd2048;

  logic            clk;
  logic            rst;
  logic            q_valid, q_ready, q_last;
  logic [1:0]      q_base;
  logic            t_valid, t_ready, t_last;
  logic [1:0]      t_base;
  logic            arr_rst, arr_en;
  logic [1:0]      arr_data;
  logic [2*LEN-1:0] arr_query;
  logic [LOGL-1:0] arr_counter;
  logic [SW-1:0]   arr_result;
  logic            arr_vld;
  logic            res_valid, res_ready, res_timeout, busy;
  logic [SW-1:0]   res_score;

  sw_score_controller #(
    .SCORE_WIDTH (SW),
    .LENGTH      (LEN),
    .LOG_LENGTH  (LOGL),
    .TIMEOUT     (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .q_valid     (q_valid),
    .q_ready     (q_ready),
    .q_base      (q_base),
    .q_last      (q_last),
    .t_valid     (t_valid),
    .t_ready     (t_ready),
    .t_base      (t_base),
    .t_last      (t_last),
    .arr_rst     (arr_rst),
    .arr_en      (arr_en),
    .arr_data    (arr_data),
    .arr_query   (arr_query),
    .arr_counter (arr_counter),
    .arr_result  (arr_result),
    .arr_vld     (arr_vld),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_score   (res_score),
    .res_timeout (res_timeout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] score;
    logic          tmo;
  } res_t;

  int         total = 0;
  int         bad   = 0;
  res_t       exp_res[$];
  logic [1:0] exp_t[$];
  logic [1:0] model_q[$];
  logic [1:0] tgt_q[$];
  bit         model_loaded = 0;
  logic [1:0] last_data = 2'b00;
  int         low_run = 0;
  res_t       mon_r;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected query bus: base k sits at bit offset 2k, unused slots are zero.
  function automatic logic [255:0] exp_query();
    logic [255:0] v;
    v = '0;
    foreach (model_q[k]) v = v | (256'(model_q[k]) << (2 * k));
    return v;
  endfunction

  // Array data scoreboard: every arr_en pulse must match the next accepted target beat.
  always @(negedge clk) begin
    if (!rst) begin
      last_data = 2'b00;
    end else if (arr_en) begin
      if (exp_t.size() == 0) begin
        chk("arr_en_spurious", 256'(arr_en), 256'(0));
      end else begin
        last_data = exp_t.pop_front();
        chk("arr_data", 256'(arr_data), 256'(last_data));
      end
    end else begin
      chk("arr_data_hold", 256'(arr_data), 256'(last_data));
    end
  end

  // Result scoreboard: pops on every completed result transfer.
  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      if (exp_res.size() == 0) begin
        chk("res_spurious", 256'(res_valid), 256'(0));
      end else begin
        mon_r = exp_res.pop_front();
        chk("res_score", 256'(res_score), 256'(mon_r.score));
        chk("res_timeout", 256'(res_timeout), 256'(mon_r.tmo));
      end
    end
  end

  // Every array clear while out of reset lasts exactly two cycles.
  always @(negedge clk) begin
    if (!rst) begin
      low_run = 0;
    end else if (!arr_rst) begin
      low_run++;
    end else if (low_run != 0) begin
      chk("clear_length", 256'(low_run), 256'(2));
      low_run = 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arr_rst"}, 256'(arr_rst), 256'(0));
    chk({tag, "_arr_en"}, 256'(arr_en), 256'(0));
    chk({tag, "_arr_data"}, 256'(arr_data), 256'(0));
    chk({tag, "_arr_query"}, arr_query, 256'(0));
    chk({tag, "_arr_counter"}, 256'(arr_counter), 256'(0));
    chk({tag, "_res_valid"}, 256'(res_valid), 256'(0));
    chk({tag, "_res_score"}, 256'(res_score), 256'(ZV));
    chk({tag, "_res_timeout"}, 256'(res_timeout), 256'(0));
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_q_ready"}, 256'(q_ready), 256'(0));
    chk({tag, "_t_ready"}, 256'(t_ready), 256'(0));
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("arr_rst_after_release", 256'(arr_rst), 256'(1));
  endtask

  task automatic send_q(input logic [1:0] b, input logic l);
    int n;
    bit got;
    n = 0;
    got = 0;
    q_valid = 1'b1;
    q_base  = b;
    q_last  = l;
    while (!got && n < 50) begin
      @(negedge clk);
      got = q_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) chk("q_handshake_bound", 256'(got), 256'(1));
  endtask

  task automatic send_t(input logic [1:0] b, input logic l);
    int n;
    bit got;
    n = 0;
    got = 0;
    t_valid = 1'b1;
    t_base  = b;
    t_last  = l;
    while (!got && n < 50) begin
      @(negedge clk);
      got = t_ready;
      if (got) exp_t.push_back(b);
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) chk("t_handshake_bound", 256'(got), 256'(1));
  endtask

  task automatic load_query(input bit use_last, input bit hold_q);
    for (int k = 0; k < model_q.size(); k++) begin
      send_q(model_q[k], use_last && (k == model_q.size() - 1));
    end
    if (hold_q) q_last = 1'b0;
    else q_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("t_ready_latency", 256'(t_ready), 256'(i == 3));
      if (hold_q) chk("q_ready_after_full", 256'(q_ready), 256'(0));
    end
    q_valid = 1'b0;
    model_loaded = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_q(input int n);
    model_q.delete();
    for (int k = 0; k < n; k++) model_q.push_back(2'($urandom_range(0, 3)));
  endtask

  task automatic fill_t(input int n);
    tgt_q.delete();
    for (int k = 0; k < n; k++) tgt_q.push_back(2'($urandom_range(0, 3)));
  endtask

  // d < 0 means the array never answers and the job must time out.
  task automatic run_job(input bit new_q, input bit use_last, input bit hold_q, input bit bubbles,
                         input int d, input logic [SW-1:0] score, input bit bp);
    res_t e;
    int   lat;
    bit   seen;
    if (new_q) load_query(use_last, hold_q);
    foreach (tgt_q[k]) begin
      if (bubbles && k > 0) begin
        t_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_t(tgt_q[k], k == tgt_q.size() - 1);
    end
    t_valid = 1'b0;
    t_last  = 1'b0;
    chk("arr_query", arr_query, exp_query());
    chk("arr_counter", 256'(arr_counter), 256'(model_q.size() - 1));
    e.score = (d >= 0) ? score : ZV;
    e.tmo   = (d < 0);
    exp_res.push_back(e);
    arr_result = score;
    arr_vld    = (d == 0);
    lat  = 0;
    seen = 0;
    while (!seen && lat < TMO + 10) begin
      @(posedge clk);
      lat++;
      #1;
      seen    = res_valid;
      arr_vld = (d > 0) && (lat == d);
    end
    arr_vld = 1'b0;
    chk("res_latency", 256'(lat), 256'((d >= 0) ? d + 1 : TMO));
    if (bp) begin
      q_valid = 1'b1;
      t_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk("bp_res_valid", 256'(res_valid), 256'(1));
        chk("bp_res_score", 256'(res_score), 256'(e.score));
        chk("bp_res_timeout", 256'(res_timeout), 256'(e.tmo));
        chk("bp_q_ready", 256'(q_ready), 256'(0));
        chk("bp_t_ready", 256'(t_ready), 256'(0));
      end
      q_valid = 1'b0;
      t_valid = 1'b0;
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    chk("busy_after_result", 256'(busy), 256'(0));
  endtask

  initial begin
    rst = 1'b0;
    q_valid = 1'b0; q_base = 2'b00; q_last = 1'b0;
    t_valid = 1'b0; t_base = 2'b00; t_last = 1'b0;
    arr_result = '0; arr_vld = 1'b0; res_ready = 1'b0;

    #12;
    check_reset_outputs("reset");
    release_reset();

    // Query AGTC, target AGTC, arr_vld 5 cycles into DRAIN, held result.
    model_q = {_A, _G, _T, _C};
    tgt_q   = {_A, _G, _T, _C};
    run_job(1, 1, 0, 0, 5, ZV + 12'd20, 1);
    // Second target reuses the stored query.
    fill_t(3);
    run_job(0, 1, 0, 0, 2, 12'($urandom), 0);

    // Full-length query without q_last; an extra beat is offered afterwards.
    fill_q(LEN);
    fill_t(2);
    run_job(1, 0, 1, 0, 0, 12'($urandom), 0);

    // Target bubbles on alternate cycles.
    fill_q(7);
    fill_t(8);
    run_job(1, 1, 0, 1, 10, 12'($urandom), 0);

    // Single-beat target with no array answer.
    fill_t(1);
    run_job(0, 1, 0, 0, -1, 12'($urandom), 0);

    // One-base query with a one-base target.
    fill_q(1);
    fill_t(1);
    run_job(1, 1, 0, 0, 3, 12'($urandom), 0);

    for (int j = 0; j < 6; j++) begin
      bit nq;
      nq = !model_loaded || ($urandom_range(0, 1) == 1);
      if (nq) fill_q($urandom_range(1, 30));
      fill_t($urandom_range(1, 10));
      run_job(nq, 1, 0, $urandom_range(0, 1) == 1,
              ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 30)),
              12'($urandom), $urandom_range(0, 1) == 1);
    end

    // Reset in the middle of STREAM.
    fill_q(5);
    load_query(1, 0);
    for (int k = 0; k < 3; k++) send_t(2'($urandom_range(0, 3)), 1'b0);
    t_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_t.delete();
    model_loaded = 0;
    release_reset();
    t_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_query_t_ready", 256'(t_ready), 256'(0));
      chk("no_query_busy", 256'(busy), 256'(0));
    end
    t_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("res_queue_drained", 256'(exp_res.size()), 256'(0));
    chk("data_queue_drained", 256'(exp_t.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sw_score_controller.md
# sw_score_controller

Sequencer for the systolic Smith-Waterman scoring array. It loads a query base-by-base into a parallel query register and clears the array between jobs. It then streams target bases into PE0 with a valid/ready handshake, selects the last active PE through the array's counter input, and returns one score per job on a result handshake. It sits between the host-side sequence streams and the scoring array.

## Interface
- SCORE_WIDTH, 12, score width; must match the array.
- LENGTH, 128, number of PEs, which is also the maximum query length.
- LOG_LENGTH, log2b(LENGTH), PE index width.
- TIMEOUT, 2*LENGTH+8, maximum number of DRAIN cycles.
- ZERO, 2**(SCORE_WIDTH-1), biased-zero score.

- clk  in  1  Clock. One clock domain only.
- rst  in  1  Asynchronous, active-low reset.
- q_valid / q_ready  in / out  1 / 1  Query-base handshake.
- q_base  in  2  Nucleotide code: A=00, G=01, T=10, C=11.
- q_last  in  1  Marks the final query base.
- t_valid / t_ready  in / out  1 / 1  Target-base handshake.
- t_base  in  2  Target nucleotide.
- t_last  in  1  Marks the final target base.
- arr_rst  out  1  Active-low array reset.
- arr_en  out  1  Drives the array en_in.
- arr_data  out  2  Drives the array data_in.
- arr_query  out  2*LENGTH  Query bus. Base k is on bits [2k+1:2k].
- arr_counter  out  LOG_LENGTH  Drives the array counter_in; equals qlen-1.
- arr_result  in  SCORE_WIDTH  Array result output.
- arr_vld  in  1  Array valid output.
- res_valid / res_ready  out / in  1 / 1  Result handshake.
- res_score  out  SCORE_WIDTH  Job score, biased representation.
- res_timeout  out  1  Set when the job ended by timeout.
- busy  out  1  High whenever the state is not IDLE.

## Operation
States are IDLE, LOAD_Q, CLEAR, STREAM, DRAIN and DONE.

- **IDLE**
  - q_valid starts a new query: the query register and qlen are zeroed, and the state moves to LOAD_Q.
  - Otherwise, t_valid with q_loaded=1 moves the state to CLEAR, so a stored query is reused.
  - t_valid with q_loaded=0 is ignored; t_ready stays 0.
  - If q_valid and t_valid are high together, the query load wins.
- **LOAD_Q**
  - q_ready=1.
  - Each accepted beat writes slot qlen, then qlen increments.
  - The state moves to CLEAR when q_last is accepted, or when the LENGTH-th base is accepted, whichever comes first. Any further query beats belong to the next job.
  - On exit, q_loaded is set to 1.
  - arr_counter = qlen-1. Unused query slots hold 00.
- **CLEAR**
  - arr_rst=0 for exactly 2 cycles, then the state moves to STREAM.
  - q_ready=0 and t_ready=0.
- **STREAM**
  - t_ready=1.
  - Each accepted beat produces arr_en=1 and arr_data=t_base on the next cycle.
  - A cycle with no transfer produces arr_en=0; arr_data holds its last value.
  - When t_last is accepted, the state moves to DRAIN.
- **DRAIN**
  - arr_en=0 and t_ready=0. The drain counter counts up from 0.
  - If arr_vld=1 is sampled, res_score=arr_result, res_timeout=0, and the state moves to DONE.
  - If the counter reaches TIMEOUT-1 first, res_score=ZERO, res_timeout=1, and the state moves to DONE.
- **DONE**
  - res_valid=1.
  - res_score and res_timeout are held until res_ready is seen; the state then returns to IDLE.
- **Stability:** arr_query and arr_counter stay stable from the end of LOAD_Q until the next LOAD_Q.

## Timing
- **Reset values:**
  - state=IDLE, q_loaded=0, qlen=0.
  - arr_rst=0 while rst=0, rising to 1 on the first clk edge after rst is released.
  - arr_en=0, arr_data=00, arr_query=0, arr_counter=0.
  - res_valid=0, res_score=ZERO, res_timeout=0, busy=0.
  - q_ready=0 and t_ready=0.
- **Registered outputs:** all outputs are registered except q_ready, t_ready and busy, which are decoded combinationally from the state.
- **Latency:**
  - Accepted target beat to arr_en: 1 cycle.
  - arr_vld sampled to res_valid: 1 cycle.
  - End of load to first t_ready: 3 cycles (2 in CLEAR, 1 to enter STREAM).
- **Reset mid-job:** all state aborts immediately, q_loaded is cleared, and the array is held in reset.
- **Result handshake:** res_valid with res_ready high in the same cycle completes the transfer; the block returns to IDLE on the next cycle.
- **Single-beat jobs:** a one-base target (t_last on the first beat) is legal, as is a one-base query (arr_counter=0).
- **Overflow:** the drain counter saturates and never wraps. qlen never exceeds LENGTH.

## Structure
- Shared package sw_pkg holds:
  - nucleotide codes _A, _G, _T, _C;
  - ZERO;
  - the state encoding;
  - log2b.
- One sub-module, sw_query_loader. It contains the query register, qlen, and the slot-write and q_last/full detection. The FSM, CLEAR timer and drain counter stay in the top level.

## Test plan
- **Query reuse:** load query AGTC with q_last on the 4th beat, then target AGTC → arr_counter=3, arr_rst low for exactly 2 cycles, arr_data follows the target one cycle after each transfer. Then a second target with no new query → CLEAR occurs and the same arr_query is used.
- **Full-length query:** send LENGTH query beats without q_last → load ends on beat LENGTH, arr_counter=LENGTH-1, and the next q beat is not accepted until the next IDLE.
- **Target bubbles:** toggle t_valid on alternate cycles → arr_en pulses only for transferred beats, and arr_data holds during gaps.
- **Result and back-pressure:** model arr_vld rising 5 cycles into DRAIN with arr_result=ZERO+20 → res_score=ZERO+20, res_timeout=0. Hold res_ready=0 for 10 cycles → outputs stay stable, and t_ready/q_ready stay 0.
- **Timeout:** keep arr_vld=0 → after TIMEOUT DRAIN cycles, res_valid=1, res_timeout=1, res_score=ZERO.
- **Reset mid-stream:** assert rst mid-STREAM → all outputs return to their reset values asynchronously. A following t_valid in IDLE is not accepted because q_loaded=0.
